// File: rtl/uart_pkg.sv
// Shared types and constants for the arbitrated UART transmitter.
// State encoding, frame-level bit values and width helpers.
package uart_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SYNC  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SYNC  = ST_SYNC,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_e;

  localparam int DATA_BITS_DEF = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side bundle of the shared UART transmitter.
// master drives requests and bit ticks, slave is the transmitter.
interface uart_tx_arb_if
  import uart_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATA_BITS = DATA_BITS_DEF
);

  localparam int IDW = id_width(NUM_REQ);

  logic                          baud_tick;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_BITS-1:0]  req_data;
  logic [NUM_REQ-1:0]            ack;
  logic                          tx;
  logic                          busy;
  logic [IDW-1:0]                owner;
  logic                          done;

  modport master (
    output baud_tick,
    output req,
    output req_data,
    input  ack,
    input  tx,
    input  busy,
    input  owner,
    input  done
  );

  modport slave (
    input  baud_tick,
    input  req,
    input  req_data,
    output ack,
    output tx,
    output busy,
    output owner,
    output done
  );

endinterface

// File: rtl/uart_tx_arb_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// ptr names the requester with highest priority this round.
module rr_arbiter
  import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx,
    output logic               gnt_vld
);

  always_comb begin
    logic [IDW-1:0] j;
    j       = '0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IDW'((int'(ptr) + k) % NUM_REQ);
      if (!gnt_vld && req[j]) begin
        gnt_vld = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = j;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin shared 8N1 UART transmitter.
// Grants one requester, captures its byte and serialises it on baud ticks.
module uart_tx_arb
  import uart_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATA_BITS = DATA_BITS_DEF
) (
    input logic         clk,
    input logic         reset_n,
    uart_tx_arb_if.slave bus
);

  localparam int IDW = id_width(NUM_REQ);
  localparam int CW  = id_width(DATA_BITS);

  localparam logic [CW-1:0]  LAST_BIT = CW'(DATA_BITS - 1);
  localparam logic [IDW-1:0] LAST_ID  = IDW'(NUM_REQ - 1);

  state_e state_q;
  state_e state_d;

  logic tx_q;
  logic tx_d;
  logic busy_q;
  logic busy_d;
  logic done_q;
  logic done_d;
  logic fresh_q;
  logic fresh_d;

  logic [NUM_REQ-1:0]   ack_q;
  logic [NUM_REQ-1:0]   ack_d;
  logic [IDW-1:0]       owner_q;
  logic [IDW-1:0]       owner_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;

  logic [IDW-1:0]       prio;
  logic [NUM_REQ-1:0]   gnt;
  logic [IDW-1:0]       gnt_idx;
  logic                 gnt_vld;
  logic [DATA_BITS-1:0] sel;

  // Until the first grant after reset, requester 0 has top priority.
  always_comb begin
    prio = '0;
    if (!fresh_q && owner_q != LAST_ID) begin
      prio = owner_q + 1'b1;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req     (bus.req),
    .ptr     (prio),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel = bus.req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ack_d   = '0;
    owner_d = owner_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    fresh_d = fresh_q;
    unique case (state_q)
      IDLE: begin
        tx_d = STOP_BIT;
        if (gnt_vld) begin
          ack_d   = gnt;
          owner_d = gnt_idx;
          shift_d = sel;
          busy_d  = 1'b1;
          fresh_d = 1'b0;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (bus.baud_tick) begin
          tx_d    = START_BIT;
          state_d = START;
        end
      end
      START: begin
        if (bus.baud_tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bus.baud_tick) begin
          if (cnt_q == LAST_BIT) begin
            tx_d    = STOP_BIT;
            state_d = STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.baud_tick) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tx_q    <= STOP_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fresh_q <= 1'b1;
      ack_q   <= '0;
      owner_q <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fresh_q <= fresh_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.tx    = tx_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.ack   = ack_q;
  assign bus.owner = owner_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomised scoreboard bench for uart_tx_arb.
// Model: the line is granted round-robin and held for 11 bit ticks.
module tb_uart_tx_arb;

  localparam int N       = 3;
  localparam int DB      = 8;
  localparam int N_TICKS = DB + 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  uart_tx_arb_if #(.NUM_REQ(N), .DATA_BITS(DB)) u_if ();

  uart_tx_arb #(.NUM_REQ(N), .DATA_BITS(DB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  always #5 clk = ~clk;

  logic [N-1:0]  pend;
  logic [N-1:0]  keep;
  logic [DB-1:0] pdata [N];
  int  tick_per;
  int  tick_cnt;
  bit  rnd_en;
  bit  mon_en;

  int  m_last;
  int  m_ticks;
  int  m_grants;
  int  rel;
  bit  m_free;
  bit  m_busy;

  int            q_ack[$];
  logic [DB-1:0] q_frame[$];
  logic [1:0]    q_bd[$];
  int            ack_log[$];

  int n_vec;
  int n_err;
  int n_ack;
  int n_done;

  int            d_st;
  int            d_bits;
  int            d_gap;
  int            d_frames;
  logic [DB-1:0] d_byte;
  logic          tx_prev;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    bit tk;
    int w;
    bit dn;
    @(negedge clk);
    if (rel >= 0) begin
      if (keep[rel]) pdata[rel] = DB'($urandom);
      else pend[rel] = 1'b0;
      rel = -1;
    end
    if (rnd_en) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(7) == 0) begin
          pend[i]  = 1'b1;
          pdata[i] = DB'($urandom);
          keep[i]  = ($urandom_range(3) == 0);
        end else if (pend[i] && $urandom_range(59) == 0) begin
          pend[i] = 1'b0;
        end
      end
    end
    if (tick_per == 0) begin
      tk = ($urandom_range(2) == 0);
    end else begin
      tick_cnt++;
      tk = (tick_cnt >= tick_per);
      if (tk) tick_cnt = 0;
    end
    u_if.baud_tick = tk;
    u_if.req       = pend;
    for (int i = 0; i < N; i++) u_if.req_data[i*DB +: DB] = pdata[i];
    dn = 1'b0;
    if (m_free) begin
      if (pend != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && pend[(m_last + k) % N]) w = (m_last + k) % N;
        end
        q_ack.push_back(w);
        q_frame.push_back(pdata[w]);
        m_last  = w;
        m_free  = 1'b0;
        m_busy  = 1'b1;
        m_ticks = 0;
        m_grants++;
        rel = w;
      end
    end else if (tk) begin
      m_ticks++;
      if (m_ticks == N_TICKS) begin
        dn     = 1'b1;
        m_busy = 1'b0;
        m_free = 1'b1;
      end
    end
    q_bd.push_back({m_busy, dn});
    @(posedge clk);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (!(m_free && pend == '0) && c < 600) begin
      step();
      c++;
    end
    if (c >= 600) chk("drain_timeout", 32'(c), 32'(0));
    repeat (4) step();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset_n = 1'b0;
    pend = '0;
    keep = '0;
    u_if.req = '0;
    u_if.baud_tick = 1'b0;
    rel = -1;
    q_ack.delete();
    q_frame.delete();
    q_bd.delete();
    ack_log.delete();
    m_last = -1;
    m_free = 1'b1;
    m_busy = 1'b0;
    m_ticks = 0;
    m_grants = 0;
    tick_cnt = 0;
    n_ack = 0;
    n_done = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mon_en = 1'b1;
  endtask

  always @(posedge clk) begin
    logic [1:0] e;
    int w;
    #1;
    if (!reset_n || !mon_en) begin
      d_st = 0;
      d_bits = 0;
      d_gap = 0;
      d_frames = 0;
      tx_prev = 1'b1;
    end else begin
      if (q_bd.size() > 0) begin
        e = q_bd.pop_front();
        chk("busy", 32'(u_if.busy), 32'(e[1]));
        chk("done", 32'(u_if.done), 32'(e[0]));
      end
      if (u_if.done) n_done++;
      if (u_if.ack != '0) begin
        n_ack++;
        ack_log.push_back(int'(u_if.owner));
        if (q_ack.size() == 0) begin
          chk("ack_spurious", 32'(u_if.ack), 32'(0));
        end else begin
          w = q_ack.pop_front();
          chk("ack", 32'(u_if.ack), 32'(1) << w);
          chk("owner", 32'(u_if.owner), 32'(w));
        end
      end
      if (!u_if.baud_tick) chk("tx_hold", 32'(u_if.tx), 32'(tx_prev));
      if (u_if.baud_tick) begin
        case (d_st)
          0: begin
            if (u_if.tx === 1'b0) begin
              if (d_frames > 0) chk("gap", 32'(d_gap), 32'(d_gap < 1 ? 1 : d_gap));
              d_st = 1;
              d_bits = 0;
            end else begin
              d_gap++;
            end
          end
          1: begin
            d_byte[d_bits] = u_if.tx;
            d_bits++;
            if (d_bits == DB) d_st = 2;
          end
          default: begin
            chk("stop_bit", 32'(u_if.tx), 32'(1));
            if (q_frame.size() == 0) chk("frame_spurious", 32'(d_byte), 32'hFFFF);
            else chk("frame", 32'(d_byte), 32'(q_frame.pop_front()));
            d_frames++;
            d_gap = 0;
            d_st = 0;
          end
        endcase
      end
      tx_prev = u_if.tx;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int base;
    n_vec = 0;
    n_err = 0;
    mon_en = 1'b0;
    rnd_en = 1'b0;
    tick_per = 4;
    pend = '0;
    keep = '0;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    u_if.req = '0;
    u_if.req_data = '0;
    u_if.baud_tick = 1'b0;

    @(posedge clk);
    #1;
    chk("rst_tx", 32'(u_if.tx), 32'(1));
    chk("rst_busy", 32'(u_if.busy), 32'(0));
    chk("rst_ack", 32'(u_if.ack), 32'(0));
    chk("rst_done", 32'(u_if.done), 32'(0));
    chk("rst_owner", 32'(u_if.owner), 32'(0));
    do_reset();

    tick_per = 4;
    pend[0] = 1'b1;
    pdata[0] = 8'hA5;
    drain();
    chk("a5_owner", 32'(u_if.owner), 32'(0));
    chk("a5_acks", 32'(ack_log.size()), 32'(1));

    do_reset();
    pend = 3'b011;
    keep = 3'b011;
    pdata[0] = 8'h11;
    pdata[1] = 8'h22;
    c = 0;
    while (m_grants < 4 && c < 1000) begin
      step();
      c++;
      pdata[0] = 8'h11;
      pdata[1] = 8'h22;
    end
    keep = '0;
    if (rel < 0) pend = '0;
    else pend = pend & (3'b001 << rel);
    drain();
    pend = '0;
    if (ack_log.size() < 4) begin
      chk("order_count", 32'(ack_log.size()), 32'(4));
    end else begin
      for (int i = 0; i < 4; i++) chk("order", 32'(ack_log[i]), 32'(i % 2));
    end

    ack_log.delete();
    pend[0] = 1'b1;
    pdata[0] = DB'($urandom);
    repeat (10) step();
    pend[1] = 1'b1;
    pdata[1] = 8'h77;
    step();
    pend[1] = 1'b0;
    drain();
    #1;
    chk("cancel_busy", 32'(u_if.busy), 32'(0));
    chk("cancel_tx", 32'(u_if.tx), 32'(1));
    chk("cancel_acks", 32'(ack_log.size()), 32'(1));

    pend[0] = 1'b1;
    pdata[0] = 8'h55;
    c = 0;
    while (!(!m_free && m_ticks == 5) && c < 200) begin
      step();
      c++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_tx", 32'(u_if.tx), 32'(1));
    chk("async_busy", 32'(u_if.busy), 32'(0));
    chk("async_ack", 32'(u_if.ack), 32'(0));
    do_reset();
    pend[0] = 1'b1;
    pdata[0] = 8'h3C;
    drain();
    chk("post_rst_acks", 32'(ack_log.size()), 32'(1));

    tick_per = 1;
    tick_cnt = 0;
    pend[2] = 1'b1;
    pdata[2] = DB'($urandom);
    drain();

    tick_per = 4;
    base = ack_log.size();
    pend[0] = 1'b1;
    keep[0] = 1'b1;
    pdata[0] = DB'($urandom);
    repeat (150) step();
    keep = '0;
    if (rel != 0) pend = '0;
    drain();
    chk("b2b_frames", 32'(ack_log.size() - base >= 3), 32'(1));

    tick_per = 0;
    rnd_en = 1'b1;
    repeat (2000) step();
    rnd_en = 1'b0;
    keep = '0;
    if (rel < 0) pend = '0;
    else pend = pend & (3'b001 << rel);
    drain();

    chk("queues_empty", 32'(q_ack.size() + q_frame.size()), 32'(0));
    chk("done_eq_ack", 32'(n_done), 32'(n_ack));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Shares one UART serial transmit line between NUM_REQ requesters. It arbitrates round-robin, captures the winner's byte and serialises it as an 8N1 frame (start, LSB-first data, stop). Bit timing comes from the baud_tick strobe of the existing baud generator. It sits between on-chip clients (CPU bus bridge, debug port) and the uart_tx pin.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_BITS, 8, data bits per frame
IDW, $clog2(NUM_REQ) with minimum 1, owner-id width (localparam)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
baud_tick  in  1  one-cycle strobe, one per bit period, from baud generator
req  in  NUM_REQ  per-requester send request; level, held until ack
req_data  in  NUM_REQ*DATA_BITS  flattened bytes; requester i at [i*DATA_BITS +: DATA_BITS]
ack  out  NUM_REQ  one-hot, one-cycle pulse; byte of that requester captured this cycle
tx  out  1  serial line, idle high
busy  out  1  high from grant cycle until frame end
owner  out  IDW  id of current/last granted requester
done  out  1  one-cycle pulse when stop bit period completes

Behaviour:
- Reset (async, reset_n low): tx=1, busy=0, ack=0, done=0, owner=0, state=IDLE, rr pointer=0, shift reg/bit counter=0. Takes effect mid-frame immediately; any partial frame is abandoned.
- All outputs are registered.
- States: IDLE, SYNC, START, DATA, STOP.
- IDLE: tx=1. If req!=0, grant the first set bit searching from (last_owner+1) mod NUM_REQ, wrapping. Grant is registered: next edge ack[i]=1 for one cycle, owner=i, shift reg=req_data slice i, busy=1, go SYNC. A baud_tick in IDLE is ignored.
- SYNC: wait for baud_tick; on it tx<=0 and go START. This aligns the start bit to a full baud period.
- START: on baud_tick tx<=shift[0], shift right, bitcnt=0, go DATA.
- DATA: on baud_tick, if bitcnt==DATA_BITS-1 then tx<=1 and go STOP; else tx<=shift[0], shift, bitcnt+1.
- STOP: on baud_tick, done=1 for one cycle, busy=0, go IDLE. tx stays 1.
- Every bit, including the start bit, is exactly one baud_tick interval wide. The frame spans DATA_BITS+2 intervals after SYNC.
- The requester must hold req and req_data stable until ack. Deasserting req before ack cancels that request with no side effect. req stays high after ack means a new request, arbitrated in the next IDLE.
- Back-to-back frames: next grant comes in the cycle after the STOP to IDLE edge, then SYNC. This gives at least one extra idle-high bit period between frames.
- Rotation: rr pointer = owner; only updated on a grant. A single persistent requester is granted repeatedly.
- baud_tick on consecutive cycles is legal: one bit per tick.
- bitcnt width is $clog2(DATA_BITS); it does not wrap within a frame.

Decomposition:
- Shared package uart_pkg: state encoding localparams (IDLE..STOP), DATA_BITS default, frame constants (START_BIT=0, STOP_BIT=1).
- One sub-module: rr_arbiter (NUM_REQ req vector plus pointer in, one-hot grant plus index out, purely combinational, rotate-by-pointer priority). The FSM and shifter stay in uart_tx_arb.

Test Plan:
- Single request: baud_tick every 4 clks; req[0]=1 with data 0xA5 -> ack[0] for 1 cycle. After the next tick, tx shows 0,1,0,1,0,0,1,0,1,1, each held 4 clks. done pulses once; owner=0.
- Contention: req=2'b11 held with data0=0x11, data1=0x22 from reset -> grant order 0,1,0,1. Frames carry 0x11,0x22,0x11,0x22; ack never two-hot.
- Cancel: req[1] pulsed high for 1 cycle while busy on requester 0 -> no ack[1]; after the frame, tx stays idle and busy=0.
- Reset mid-frame: reset_n low during DATA bit 3 -> tx=1, busy=0, ack=0 in the same cycle (async). After release, a new req[0]=0x3C produces a clean full frame.
- Tick edge cases: baud_tick high in the grant cycle is ignored (start bit begins at the following tick). baud_tick every cycle yields a 10-cycle frame with correct bits.
- Back-to-back: req[0] held continuously -> at least one idle-high baud period between stop bit and next start bit; done count equals ack count.
